byte_dispatch: RTL and testbench



---
 rtl/aes_pkg.sv | 17 +
 rtl/byte_fifo.sv | 62 ++++++
 rtl/byte_dispatch.sv | 108 ++++++++++
 tb/tb_byte_dispatch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-stream definitions: byte width, block size and destination encodings.
package aes_pkg;

  localparam int BYTE_W          = 8;
  localparam int AES_BLOCK_BYTES = 16;

  localparam logic DEST_CIPHER = 1'b0;
  localparam logic DEST_INV    = 1'b1;

  typedef logic [BYTE_W-1:0] byte_t;

  // Index of the final byte in a block, sized to the block counter.
  function automatic logic [$clog2(AES_BLOCK_BYTES)-1:0] lastIndex(input int blockBytes);
    return ($clog2(AES_BLOCK_BYTES))'(blockBytes - 1);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with push/full and pop/empty handshakes; the head output holds the last
// popped byte while the FIFO is empty so consumers never see undefined data.
module byte_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  byte_t pushData_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output byte_t data_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count_q, count_d;
  byte_t            mem_q [DEPTH];
  byte_t            last_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = empty_o ? last_q : mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      count_q <= count_d;
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
        last_q  <= mem_q[rdPtr_q];
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/byte_dispatch.sv
// Steers one byte stream to one of two FIFO-backed outputs, latching the destination per block.
// Optional BYTE_DISPATCH_ABORT_EN adds Abort/BlockAborted to cut a block short.
module byte_dispatch
  import aes_pkg::*;
#(
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic  Clock,
  input  logic  Reset_n,
  input  logic  Select,
  input  byte_t InputByte,
  input  logic  InputByteReady,
  output logic  InputAccept,
  output byte_t OutputByte1,
  output logic  OutputByteReady1,
  input  logic  OutputAccept1,
  output byte_t OutputByte2,
  output logic  OutputByteReady2,
  input  logic  OutputAccept2,
`ifdef BYTE_DISPATCH_ABORT_EN
  input  logic  Abort,
  output logic  BlockAborted,
`endif
  output logic  BlockActive,
  output logic  BlockDest
);

  localparam int CNT_W = $clog2(BLOCK_BYTES);

  logic [CNT_W-1:0] count_q, count_d;
  logic             dest_q, dest_d;
  logic             effDest, accepted;
  logic             full1, full2, empty1, empty2;
  logic             push1, push2;
`ifdef BYTE_DISPATCH_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  // Select only matters at a block boundary; mid-block the latched destination rules.
  assign effDest     = (count_q == '0) ? Select : dest_q;
  assign InputAccept = (effDest == DEST_INV) ? !full2 : !full1;
  assign accepted    = InputByteReady && InputAccept;
  assign push1       = accepted && (effDest == DEST_CIPHER);
  assign push2       = accepted && (effDest == DEST_INV);

  assign BlockActive = (count_q != '0);
  assign BlockDest   = dest_q;

  assign OutputByteReady1 = !empty1;
  assign OutputByteReady2 = !empty2;

  always_comb begin
    count_d = count_q;
    dest_d  = dest_q;
    if (accepted) begin
      if (count_q == '0) dest_d = Select;
      count_d = (count_q == CNT_W'(BLOCK_BYTES - 1)) ? '0 : count_q + 1'b1;
    end
`ifdef BYTE_DISPATCH_ABORT_EN
    aborted_d = Abort && (count_q != '0);
    if (Abort) count_d = '0;
`endif
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
      dest_q  <= DEST_CIPHER;
`ifdef BYTE_DISPATCH_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      dest_q  <= dest_d;
`ifdef BYTE_DISPATCH_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

`ifdef BYTE_DISPATCH_ABORT_EN
  assign BlockAborted = aborted_q;
`endif

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .push_i     (push1),
    .pushData_i (InputByte),
    .pop_i      (OutputAccept1),
    .full_o     (full1),
    .empty_o    (empty1),
    .data_o     (OutputByte1)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .push_i     (push2),
    .pushData_i (InputByte),
    .pop_i      (OutputAccept2),
    .full_o     (full2),
    .empty_o    (empty2),
    .data_o     (OutputByte2)
  );

endmodule

// File: tb/tb_byte_dispatch.sv
// Directed bench for byte_dispatch: reset, streaming, backpressure, block steering, mid-block reset
// and, with BYTE_DISPATCH_ABORT_EN, the abort pulse.
module tb_byte_dispatch;

  logic       Clock;
  logic       Reset_n;
  logic       Select;
  logic [7:0] InputByte;
  logic       InputByteReady;
  logic       InputAccept;
  logic [7:0] OutputByte1;
  logic       OutputByteReady1;
  logic       OutputAccept1;
  logic [7:0] OutputByte2;
  logic       OutputByteReady2;
  logic       OutputAccept2;
  logic       BlockActive;
  logic       BlockDest;
`ifdef BYTE_DISPATCH_ABORT_EN
  logic       Abort;
  logic       BlockAborted;
`endif

  int checks = 0;
  int passes = 0;

  byte_dispatch dut (
    .Clock            (Clock),
    .Reset_n          (Reset_n),
    .Select           (Select),
    .InputByte        (InputByte),
    .InputByteReady   (InputByteReady),
    .InputAccept      (InputAccept),
    .OutputByte1      (OutputByte1),
    .OutputByteReady1 (OutputByteReady1),
    .OutputAccept1    (OutputAccept1),
    .OutputByte2      (OutputByte2),
    .OutputByteReady2 (OutputByteReady2),
    .OutputAccept2    (OutputAccept2),
`ifdef BYTE_DISPATCH_ABORT_EN
    .Abort            (Abort),
    .BlockAborted     (BlockAborted),
`endif
    .BlockActive      (BlockActive),
    .BlockDest        (BlockDest)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       sel;
    logic [7:0] din;
    logic       rdy;
    logic       acc1;
    logic       acc2;
    logic       eAccept;
    logic [7:0] eOut1;
    logic       eRdy1;
    logic       eRdy2;
    logic       eActive;
    logic       eDest;
  } vec_t;

  vec_t tbl [13];

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic sel, input logic [7:0] din, input logic rdy,
                               input logic acc1, input logic acc2);
    Select         = sel;
    InputByte      = din;
    InputByteReady = rdy;
    OutputAccept1  = acc1;
    OutputAccept2  = acc2;
  endtask

  task automatic checkOutput(input string tag, input logic eAccept, input logic [7:0] eOut1,
                             input logic eRdy1, input logic eRdy2, input logic eActive,
                             input logic eDest);
    checkVal({tag, ".InputAccept"},      InputAccept,      eAccept);
    checkVal({tag, ".OutputByte1"},      OutputByte1,      eOut1);
    checkVal({tag, ".OutputByteReady1"}, OutputByteReady1, eRdy1);
    checkVal({tag, ".OutputByteReady2"}, OutputByteReady2, eRdy2);
    checkVal({tag, ".BlockActive"},      BlockActive,      eActive);
    checkVal({tag, ".BlockDest"},        BlockDest,        eDest);
  endtask

  // Advance to one time unit after the next rising edge, where new inputs get driven.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // Backpressure on output 1: four bytes fill the FIFO, then a pop frees a slot a cycle later.
    tbl[0]  = '{1'b0, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef BYTE_DISPATCH_ABORT_EN
    Abort = 1'b0;
`endif
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #2;
    checkOutput("reset", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("reset.OutputByte2", OutputByte2, 8'h00);
    @(posedge Clock);
    #1 Reset_n = 1'b1;

    // Sixteen bytes back-to-back to output 1, each visible one cycle after acceptance.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'(i), 1'b1, 1'b1, 1'b0);
      #1;
      if (i == 0) checkOutput("stream0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      else        checkOutput($sformatf("stream%0d", i), 1'b1, 8'(i - 1), 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("streamLast", 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    #1 checkOutput("streamHold", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    for (int r = 0; r < 13; r++) begin
      applyStimulus(tbl[r].sel, tbl[r].din, tbl[r].rdy, tbl[r].acc1, tbl[r].acc2);
      #1;
      checkOutput($sformatf("bp%0d", r), tbl[r].eAccept, tbl[r].eOut1, tbl[r].eRdy1,
                  tbl[r].eRdy2, tbl[r].eActive, tbl[r].eDest);
      tick();
    end

    // Seventh byte of the block, then an asynchronous reset mid-block.
    applyStimulus(1'b0, 8'hC6, 1'b1, 1'b0, 1'b0);
    #1 checkVal("preReset.InputAccept", InputAccept, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 checkVal("preReset.OutputByte1", OutputByte1, 8'hC6);
    Reset_n = 1'b0;
    #1 checkOutput("midReset", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    Reset_n = 1'b1;

    // First byte after reset opens a new block using Select=1.
    applyStimulus(1'b1, 8'hD0, 1'b1, 1'b0, 1'b1);
    #1 checkOutput("newBlk0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int j = 1; j < 16; j++) begin
      applyStimulus(1'b0, 8'hD0 + 8'(j), 1'b1, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("newBlk%0d", j), 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      checkVal($sformatf("newBlk%0d.OutputByte2", j), OutputByte2, 8'hD0 + 8'(j - 1));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("newBlkEnd", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    checkVal("newBlkEnd.OutputByte2", OutputByte2, 8'hDF);
    tick();
    #1 checkVal("newBlkDrained.OutputByteReady2", OutputByteReady2, 1'b0);
    tick();

    // Select flips to 1 at byte 5: the rest of the block still goes to output 1.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i >= 5, 8'hE0 + 8'(i), 1'b1, 1'b1, 1'b0);
      #1;
      if (i == 0) checkOutput("toggle0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      else        checkOutput($sformatf("toggle%0d", i), 1'b1, 8'hE0 + 8'(i - 1), 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'hF0, 1'b1, 1'b1, 1'b0);
    #1 checkOutput("nextBlk", 1'b1, 8'hEF, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    #1 checkOutput("nextBlkOut", 1'b1, 8'hEF, 1'b0, 1'b1, 1'b1, 1'b1);
    checkVal("nextBlkOut.OutputByte2", OutputByte2, 8'hF0);
    tick();

`ifdef BYTE_DISPATCH_ABORT_EN
    // Bring the count to 9, abort, then the next byte latches a fresh Select.
    for (int j = 1; j < 9; j++) begin
      applyStimulus(1'b0, 8'hF0 + 8'(j), 1'b1, 1'b1, 1'b1);
      #1 checkVal($sformatf("abortFill%0d.InputAccept", j), InputAccept, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    Abort = 1'b1;
    #1;
    checkVal("abortHit.BlockActive", BlockActive, 1'b1);
    checkVal("abortHit.BlockAborted", BlockAborted, 1'b0);
    tick();
    Abort = 1'b0;
    applyStimulus(1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    #1;
    checkVal("abortPulse.BlockAborted", BlockAborted, 1'b1);
    checkVal("abortPulse.BlockActive", BlockActive, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    checkVal("afterAbort.BlockAborted", BlockAborted, 1'b0);
    checkOutput("afterAbort", 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
